// File: rtl/vip_frame_ctrl_pkg.sv
// Shared definitions for the vip_frame_ctrl block: configuration map,
// control bit positions, FSM state encoding and reset defaults.
package vip_frame_ctrl_pkg;

    // Configuration register addresses
    localparam logic [1:0] CFG_EN    = 2'd0;
    localparam logic [1:0] CFG_SCALE = 2'd1;
    localparam logic [1:0] CFG_CTRL  = 2'd2;

    // Bit positions inside a CFG_CTRL write
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_SRST   = 1;
    localparam int CTRL_CLRERR = 2;

    // Pixel and line counters saturate at the top of this width
    localparam int CNT_W = 12;

    // IDLE is never a resting state: reset always walks through ST_RESET
    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FRAME   = 2'd2
    } state_e;

    // Field order matches bits [3:0] of a CFG_EN write
    typedef struct packed {
        logic dscale_en;
        logic yuv2rgb_en;
        logic sobel_en;
        logic hist_equ_en;
    } en_t;

    localparam en_t EN_RST = '{dscale_en: 1'b1, yuv2rgb_en: 1'b1,
                               sobel_en: 1'b0, hist_equ_en: 1'b0};
    localparam logic [3:0] SCALE_RST = 4'd1;

endpackage

// File: rtl/vip_frame_ctrl_if.sv
// Configuration bus and incoming video sync signals of vip_frame_ctrl.
interface vip_frame_ctrl_if;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        in_href;
    logic        in_vsync;

    modport master (output cfg_wr, cfg_addr, cfg_wdata, in_href, in_vsync);
    modport slave  (input  cfg_wr, cfg_addr, cfg_wdata, in_href, in_vsync);
endinterface

// File: rtl/vip_frame_ctrl_sync_edge.sv
// Registered edge detector: the level is registered once and the rise/fall
// pulses are registered alongside it, so all three are cycle-aligned and
// appear one cycle after the change on the input.
module vip_sync_edge (
    input  logic pclk,
    input  logic rst_n,
    input  logic sig_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;
    logic rise_q;
    logic fall_q;

    // Sample the input and flag transitions relative to the previous sample
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            sig_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            rise_q <= sig_i & ~sig_q;
            fall_q <= ~sig_i & sig_q;
        end
    end

    assign lvl_o  = sig_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/vip_frame_ctrl.sv
// Frame-synchronous controller for the vip_top chain: double-buffered
// pipeline settings applied on frame boundaries, soft-reset sequencing,
// frame lock, geometry checking and interrupt pulses.
module vip_frame_ctrl
    import vip_frame_ctrl_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 960,
    parameter int RST_CYCLES = 16,
    parameter int FCNT_BITS  = 16
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    vip_frame_ctrl_if.slave      bus,
    output logic                 pipe_rst_n,
    output logic                 hist_equ_en,
    output logic                 sobel_en,
    output logic                 yuv2rgb_en,
    output logic                 dscale_en,
    output logic [3:0]           dscale_scale,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 cfg_applied,
    output logic [FCNT_BITS-1:0] frame_cnt,
    output logic                 err_line_len,
    output logic                 err_frame_h,
    output logic                 locked
);

    localparam int               RC_W     = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(HEIGHT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Edge detection on the incoming syncs
    logic href_lvl, href_fall, vs_rise;
    logic unused_href_rise, unused_vs_lvl, unused_vs_fall;
    logic unused_wdata;

    vip_sync_edge u_href_edge (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .sig_i  (bus.in_href),
        .lvl_o  (href_lvl),
        .rise_o (unused_href_rise),
        .fall_o (href_fall)
    );

    vip_sync_edge u_vsync_edge (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .sig_i  (bus.in_vsync),
        .lvl_o  (unused_vs_lvl),
        .rise_o (vs_rise),
        .fall_o (unused_vs_fall)
    );

    assign unused_wdata = ^bus.cfg_wdata[31:4];

    // State
    state_e               state_q;
    logic [RC_W-1:0]      rst_cnt_q;
    logic                 pipe_rst_q;
    logic                 locked_q;
    logic [CNT_W-1:0]     pix_cnt_q;
    logic [CNT_W-1:0]     line_cnt_q;
    logic                 frame_start_q;
    logic                 frame_done_q;
    logic [FCNT_BITS-1:0] frame_cnt_q;

    en_t                  shadow_en_q, live_en_q;
    logic [3:0]           shadow_scale_q, live_scale_q;
    logic                 commit_pend_q, commit_pend_d;
    logic                 applied_q;
    logic                 err_line_q, err_line_d;
    logic                 err_frame_q, err_frame_d;

    // Decoded events for this cycle
    logic             ctrl_wr, soft_rst, commit_wr, clr_err;
    logic             frame_bnd, frame_close, line_end;
    logic             line_bad, frame_bad, cfg_apply;
    logic [CNT_W-1:0] lines_eff;

    // Decode control writes and the boundary/line events seen by the FSM
    always_comb begin
        ctrl_wr     = bus.cfg_wr && (bus.cfg_addr == CFG_CTRL);
        soft_rst    = ctrl_wr && bus.cfg_wdata[CTRL_SRST];
        commit_wr   = ctrl_wr && bus.cfg_wdata[CTRL_COMMIT];
        clr_err     = ctrl_wr && bus.cfg_wdata[CTRL_CLRERR];
        frame_bnd   = vs_rise && !soft_rst &&
                      ((state_q == ST_WAIT_VS) || (state_q == ST_FRAME));
        frame_close = frame_bnd && (state_q == ST_FRAME);
        line_end    = href_fall && !soft_rst && (state_q == ST_FRAME);
        line_bad    = line_end && (pix_cnt_q != WIDTH_C);
        // A line ending on the boundary cycle still belongs to the closing frame
        lines_eff   = line_end ? sat_inc(line_cnt_q) : line_cnt_q;
        frame_bad   = frame_close && (lines_eff != HEIGHT_C);
        cfg_apply   = frame_bnd && commit_pend_q;
    end

    // Next state of the sticky flags and the pending commit
    always_comb begin
        commit_pend_d = (commit_pend_q && !cfg_apply) || commit_wr;
        err_line_d    = (err_line_q && !clr_err) || line_bad;
        err_frame_d   = (err_frame_q && !clr_err) || frame_bad;
    end

    // Frame FSM: pipeline reset sequencing, lock, geometry counters, frame pulses
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q       <= ST_RESET;
            rst_cnt_q     <= RC_LOAD;
            pipe_rst_q    <= 1'b0;
            locked_q      <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= frame_bnd;
            frame_done_q  <= frame_close;
            if (frame_close) begin
                frame_cnt_q <= frame_cnt_q + FCNT_BITS'(1);
            end
            if (soft_rst) begin
                state_q    <= ST_RESET;
                rst_cnt_q  <= RC_LOAD;
                pipe_rst_q <= 1'b0;
                locked_q   <= 1'b0;
                pix_cnt_q  <= '0;
                line_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    ST_RESET: begin
                        if (rst_cnt_q <= RC_W'(1)) begin
                            pipe_rst_q <= 1'b1;
                            state_q    <= ST_WAIT_VS;
                        end else begin
                            rst_cnt_q <= rst_cnt_q - RC_W'(1);
                        end
                    end
                    ST_WAIT_VS: begin
                        if (vs_rise) begin
                            state_q    <= ST_FRAME;
                            locked_q   <= 1'b1;
                            pix_cnt_q  <= '0;
                            line_cnt_q <= '0;
                        end
                    end
                    ST_FRAME: begin
                        if (vs_rise) begin
                            pix_cnt_q  <= '0;
                            line_cnt_q <= '0;
                        end else if (href_fall) begin
                            line_cnt_q <= sat_inc(line_cnt_q);
                            pix_cnt_q  <= '0;
                        end else if (href_lvl) begin
                            pix_cnt_q <= sat_inc(pix_cnt_q);
                        end
                    end
                    default: begin
                        state_q    <= ST_RESET;
                        rst_cnt_q  <= RC_LOAD;
                        pipe_rst_q <= 1'b0;
                        locked_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Shadow/live settings, pending commit and sticky error flags
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            shadow_en_q    <= EN_RST;
            shadow_scale_q <= SCALE_RST;
            live_en_q      <= EN_RST;
            live_scale_q   <= SCALE_RST;
            commit_pend_q  <= 1'b0;
            applied_q      <= 1'b0;
            err_line_q     <= 1'b0;
            err_frame_q    <= 1'b0;
        end else begin
            if (bus.cfg_wr && (bus.cfg_addr == CFG_EN)) begin
                shadow_en_q <= en_t'(bus.cfg_wdata[3:0]);
            end
            if (bus.cfg_wr && (bus.cfg_addr == CFG_SCALE)) begin
                shadow_scale_q <= bus.cfg_wdata[3:0];
            end
            if (cfg_apply) begin
                live_en_q    <= shadow_en_q;
                live_scale_q <= shadow_scale_q;
            end
            applied_q     <= cfg_apply;
            commit_pend_q <= commit_pend_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
        end
    end

    assign pipe_rst_n   = pipe_rst_q;
    assign hist_equ_en  = live_en_q.hist_equ_en;
    assign sobel_en     = live_en_q.sobel_en;
    assign yuv2rgb_en   = live_en_q.yuv2rgb_en;
    assign dscale_en    = live_en_q.dscale_en;
    assign dscale_scale = live_scale_q;
    assign frame_start  = frame_start_q;
    assign frame_done   = frame_done_q;
    assign cfg_applied  = applied_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_line_len = err_line_q;
    assign err_frame_h  = err_frame_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Self-checking bench for vip_frame_ctrl: directed frame sequences followed by
// randomized frames, compared against a frame-level reference model.
module tb_vip_frame_ctrl;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 4;
    localparam int RST_CYCLES = 16;
    localparam int FCNT_BITS  = 3;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 pclk = ~pclk;

    vip_frame_ctrl_if bus ();

    logic                 pipe_rst_n, hist_equ_en, sobel_en, yuv2rgb_en, dscale_en;
    logic [3:0]           dscale_scale;
    logic                 frame_start, frame_done, cfg_applied;
    logic [FCNT_BITS-1:0] frame_cnt;
    logic                 err_line_len, err_frame_h, locked;

    vip_frame_ctrl #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .RST_CYCLES (RST_CYCLES),
        .FCNT_BITS  (FCNT_BITS)
    ) dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .pipe_rst_n   (pipe_rst_n),
        .hist_equ_en  (hist_equ_en),
        .sobel_en     (sobel_en),
        .yuv2rgb_en   (yuv2rgb_en),
        .dscale_en    (dscale_en),
        .dscale_scale (dscale_scale),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .cfg_applied  (cfg_applied),
        .frame_cnt    (frame_cnt),
        .err_line_len (err_line_len),
        .err_frame_h  (err_frame_h),
        .locked       (locked)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state (frame-level view of the stream)
    bit         m_locked = 0;
    int         m_lines = 0;
    bit         m_err_l = 0, m_err_h = 0;
    int         m_fcnt = 0, m_done = 0, m_start = 0, m_applied = 0;
    logic [3:0] m_sh_en = 4'hC, m_sh_sc = 4'd1, m_lv_en = 4'hC, m_lv_sc = 4'd1;
    bit         m_pend = 0;
    logic [7:0] exp_live_q[$];

    int obs_done = 0, obs_start = 0, obs_applied = 0;

    function automatic logic [7:0] live_now();
        return {dscale_en, yuv2rgb_en, sobel_en, hist_equ_en, dscale_scale};
    endfunction

    // Pulse monitor: counts pulses and checks live settings only move at frame_start
    initial begin
        logic [7:0] prev_live;
        bit         prev_rstn;
        prev_live = '0;
        prev_rstn = 0;
        forever begin
            @(negedge pclk);
            if (rst_n && prev_rstn) begin
                if (live_now() != prev_live) chk("live_chg_at_fs", frame_start, 1);
                if (frame_start) begin
                    obs_start++;
                    if (exp_live_q.size() == 0) chk("fs_unexpected", 1, 0);
                    else chk("live_at_fs", live_now(), exp_live_q.pop_front());
                end
                if (frame_done) begin
                    obs_done++;
                    chk("done_with_fs", frame_start, 1);
                end
                if (cfg_applied) begin
                    obs_applied++;
                    chk("applied_with_fs", frame_start, 1);
                end
            end
            prev_live = live_now();
            prev_rstn = rst_n;
        end
    end

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        bus.cfg_wr    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        @(negedge pclk);
        bus.cfg_wr = 1'b0;
        case (addr)
            2'd0: m_sh_en = data[3:0];
            2'd1: m_sh_sc = data[3:0];
            2'd2: begin
                if (data[1]) begin
                    m_locked = 0;
                    m_lines  = 0;
                end
                if (data[0]) m_pend = 1;
                if (data[2]) begin
                    m_err_l = 0;
                    m_err_h = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic wait_pipe_release(input string tag);
        int n;
        n = 0;
        while (pipe_rst_n === 1'b0 && n < 200) begin
            n++;
            @(negedge pclk);
        end
        chk(tag, n, RST_CYCLES);
    endtask

    task automatic model_boundary();
        m_start++;
        if (m_locked) begin
            m_done++;
            m_fcnt++;
            if (m_lines != HEIGHT) m_err_h = 1;
        end
        if (m_pend) begin
            m_lv_en = m_sh_en;
            m_lv_sc = m_sh_sc;
            m_applied++;
            m_pend = 0;
        end
        exp_live_q.push_back({m_lv_en, m_lv_sc});
        m_locked = 1;
        m_lines  = 0;
    endtask

    task automatic line(input int len);
        bus.in_href = 1'b1;
        repeat (len) @(negedge pclk);
        bus.in_href = 1'b0;
        repeat (3) @(negedge pclk);
        if (m_locked) begin
            m_lines++;
            if (len != WIDTH) m_err_l = 1;
        end
    endtask

    task automatic vs_edge();
        model_boundary();
        bus.in_vsync = 1'b1;
        repeat (2) @(negedge pclk);
        bus.in_vsync = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    // Last line of the frame ends on the very cycle vsync rises
    task automatic combo_end();
        bus.in_href = 1'b1;
        repeat (WIDTH) @(negedge pclk);
        if (m_locked) m_lines++;
        bus.in_href = 1'b0;
        vs_edge();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".frame_cnt"}, frame_cnt, m_fcnt % (1 << FCNT_BITS));
        chk({tag, ".err_line"}, err_line_len, m_err_l);
        chk({tag, ".err_frame"}, err_frame_h, m_err_h);
        chk({tag, ".locked"}, locked, m_locked);
        chk({tag, ".n_done"}, obs_done, m_done);
        chk({tag, ".n_start"}, obs_start, m_start);
        chk({tag, ".n_applied"}, obs_applied, m_applied);
        chk({tag, ".live"}, live_now(), {m_lv_en, m_lv_sc});
        chk({tag, ".pipe_rst_n"}, pipe_rst_n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, dn, nl, len, r;
        logic [31:0] d;
        bus.cfg_wr    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = '0;
        bus.in_href   = 1'b0;
        bus.in_vsync  = 1'b0;

        // 1: reset, pipeline reset length, defaults
        repeat (4) @(negedge pclk);
        chk("t1.pipe_in_reset", pipe_rst_n, 0);
        chk("t1.live_in_reset", live_now(), 8'hC1);
        rst_n = 1'b1;
        wait_pipe_release("t1.pipe_rst_len");
        repeat (4) @(negedge pclk);
        chk("t1.locked", locked, 0);
        chk("t1.frame_cnt", frame_cnt, 0);
        chk("t1.errs", {err_line_len, err_frame_h}, 0);
        chk("t1.live", live_now(), 8'hC1);
        chk("t1.pulses", {frame_start, frame_done, cfg_applied}, 0);

        // 2: three well-formed frames
        for (int f = 0; f < 3; f++) begin
            vs_edge();
            if (f == 0) chk("t2.lock_first", locked, 1);
            if (f < 2) for (int l = 0; l < HEIGHT; l++) line(WIDTH);
        end
        chk("t2.n_done", obs_done, 2);
        chk("t2.frame_cnt", frame_cnt, 2);
        check_state("t2");

        // 3: scale write plus commit mid-frame
        line(WIDTH);
        line(WIDTH);
        cfg_write(2'd1, 32'd3);
        cfg_write(2'd2, 32'h1);
        repeat (3) @(negedge pclk);
        chk("t3.scale_hold", dscale_scale, 1);
        line(WIDTH);
        line(WIDTH);
        chk("t3.scale_hold2", dscale_scale, 1);
        vs_edge();
        chk("t3.scale_new", dscale_scale, 3);
        chk("t3.n_applied", obs_applied, 1);
        check_state("t3");

        // 4: short line and short frame, then clear
        line(WIDTH - 1);
        chk("t4.err_line", err_line_len, 1);
        line(WIDTH);
        line(WIDTH);
        vs_edge();
        chk("t4.err_frame", err_frame_h, 1);
        cfg_write(2'd2, 32'h4);
        repeat (2) @(negedge pclk);
        chk("t4.cleared", {err_line_len, err_frame_h}, 0);
        for (int l = 0; l < HEIGHT; l++) line(WIDTH);
        vs_edge();
        chk("t4.clean", {err_line_len, err_frame_h}, 0);
        check_state("t4");

        // 5: soft reset mid-frame
        fc = frame_cnt;
        dn = obs_done;
        line(WIDTH);
        line(WIDTH);
        cfg_write(2'd2, 32'h2);
        wait_pipe_release("t5.pipe_rst_len");
        chk("t5.unlocked", locked, 0);
        line(WIDTH);
        vs_edge();
        chk("t5.no_done", obs_done, dn);
        chk("t5.frame_cnt", frame_cnt, fc);
        chk("t5.relock", locked, 1);
        check_state("t5");

        // 6: href fall and vsync rise on the same cycle
        for (int l = 0; l < HEIGHT - 1; l++) line(WIDTH);
        combo_end();
        chk("t6.err_frame", err_frame_h, 0);
        chk("t6.n_done", obs_done, dn + 1);
        check_state("t6");

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            nl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(HEIGHT - 1, HEIGHT + 1)) : HEIGHT;
            for (int l = 0; l < nl; l++) begin
                len = WIDTH;
                if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 1) ? WIDTH - 1 : WIDTH + 1;
                line(len);
                r = $urandom_range(0, 24);
                case (r)
                    0: cfg_write(2'd0, $urandom);
                    1: cfg_write(2'd1, $urandom);
                    2, 3: begin
                        d = 32'($urandom_range(0, 1)) | (32'($urandom_range(0, 1)) << 2);
                        cfg_write(2'd2, d);
                    end
                    4: begin
                        d = 32'h2 | 32'($urandom_range(0, 1));
                        cfg_write(2'd2, d);
                        wait_pipe_release("rnd.pipe_rst_len");
                    end
                    default: ;
                endcase
            end
            if ($urandom_range(0, 7) == 0) combo_end();
            else vs_edge();
            check_state($sformatf("rnd%0d", f));
        end

        repeat (4) @(negedge pclk);
        chk("fs_queue_drained", exp_live_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
